// File: rtl/serial_addsub.sv
// Bit-serial add/subtract sequencer around one full-adder slice, LSB first, WIDTH+1 cycles per op.
// Optional macro SERIAL_ADDSUB_SAT_EN: signed saturation of the result on overflow.
module serial_addsub #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic [CW-1:0]    cnt;
   logic             carry_q;
   logic             ovf_q;
   logic             slice_sum;
   logic             slice_cout;
   logic [WIDTH-1:0] final_result;

   // The single full-adder slice; the operand registers present one bit pair per cycle.
   assign slice_sum  = a_sr[0] ^ b_sr[0] ^ carry_q;
   assign slice_cout = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry_q) | (b_sr[0] & carry_q);

`ifdef SERIAL_ADDSUB_SAT_EN
   logic sign_q;

   // On overflow both effective operand signs agree; that sign picks the clamp direction.
   always_comb begin
      final_result = res_sr;
      if (ovf_q) begin
         final_result = sign_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sign_q <= 1'b0;
      end else if (state == SHIFT && cnt == LAST) begin
         sign_q <= a_sr[0];
      end
   end
`else
   assign final_result = res_sr;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         a_sr      <= '0;
         b_sr      <= '0;
         res_sr    <= '0;
         cnt       <= '0;
         carry_q   <= 1'b0;
         ovf_q     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
                  a_sr    <= a;
                  b_sr    <= sub ? ~b : b;
                  carry_q <= sub;
                  cnt     <= '0;
                  busy    <= 1'b1;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               res_sr  <= {slice_sum, res_sr[WIDTH-1:1]};
               a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
               b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
               carry_q <= slice_cout;
               cnt     <= cnt + CW'(1);
               if (cnt == LAST) begin
                  // carry_q is the carry into the MSB here, slice_cout the carry out of it.
                  ovf_q <= carry_q ^ slice_cout;
                  busy  <= 1'b0;
                  state <= DONE;
               end
            end
            DONE: begin
               done      <= 1'b1;
               result    <= final_result;
               carry_out <= carry_q;
               overflow  <= ovf_q;
               if (start) begin
                  a_sr    <= a;
                  b_sr    <= sub ? ~b : b;
                  carry_q <= sub;
                  cnt     <= '0;
                  busy    <= 1'b1;
                  state   <= SHIFT;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=4): directed plan vectors, random ops, back-to-back and reset abort.
module tb_serial_addsub;

   localparam int W   = 4;
   localparam int MOD = 1 << W;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         carry_out;
   logic         overflow;

   int checks   = 0;
   int failures = 0;
   int edge_cnt = 0;
   int t0       = 0;
   int busy_seen = 0;
   logic [W+1:0] last_exp = '0;
   logic [W+1:0] exp_q[$];

   serial_addsub #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .sub       (sub),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // Reference: integer arithmetic on signed/unsigned interpretations, packed as {overflow, carry, result}.
   function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      int ux, uy, sx, sy, ures, sres;
      logic c, ov;
      logic [W-1:0] r;
      ux = int'(x);
      uy = int'(y);
      sx = x[W-1] ? ux - MOD : ux;
      sy = y[W-1] ? uy - MOD : uy;
      if (s) begin
         ures = ux - uy + MOD;
         sres = sx - sy;
         c    = (ux >= uy);
      end else begin
         ures = ux + uy;
         sres = sx + sy;
         c    = (ures >= MOD);
      end
      r  = W'(ures % MOD);
      ov = (sres > (MOD / 2) - 1) || (sres < -(MOD / 2));
`ifdef SERIAL_ADDSUB_SAT_EN
      if (ov) r = (sres > 0) ? W'((MOD / 2) - 1) : W'(MOD / 2);
`endif
      return {ov, c, r};
   endfunction

   task automatic tick();
      @(negedge clk);
      if (busy) busy_seen++;
   endtask

   task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_op, input logic ts);
      a     = ta;
      b     = tb_op;
      sub   = ts;
      start = 1'b1;
      exp_q.push_back(model(ta, tb_op, ts));
      busy_seen = 0;
      tick();
      t0    = edge_cnt;
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      sub   = 1'($urandom);
   endtask

   task automatic wait_check(input string name);
      int lat;
      logic [W+1:0] e;
      while (!done && (edge_cnt - t0) < 20) tick();
      lat = edge_cnt - t0;
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL %s_timeout: done=0 after %0d cycles, required done=1 at %0d", name, lat, W + 1);
         if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else begin
         if (lat != W + 1) begin
            failures++;
            $display("FAIL %s_latency: got %0d cycles, required %0d", name, lat, W + 1);
         end
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
         last_exp = e;
         checks++;
         if ({overflow, carry_out, result} !== e) begin
            failures++;
            $display("FAIL %s_result: got ovf=%b cout=%b result=%b, required ovf=%b cout=%b result=%b",
                     name, overflow, carry_out, result, e[W+1], e[W], e[W-1:0]);
         end
         checks++;
         if (busy_seen != W) begin
            failures++;
            $display("FAIL %s_busy_cycles: got %0d, required %0d", name, busy_seen, W);
         end
      end
   endtask

   task automatic check_hold(input string name, input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || {overflow, carry_out, result} !== last_exp) begin
            failures++;
            $display("FAIL %s_hold: got done=%b busy=%b outs=%b, required done=0 busy=0 outs=%b",
                     name, done, busy, {overflow, carry_out, result}, last_exp);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b1;
      sub   = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      tick();
      tick();
      checks++;
      if ({busy, done, overflow, carry_out, result} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got busy=%b done=%b ovf=%b cout=%b result=%b, required all 0",
                  busy, done, overflow, carry_out, result);
      end
      start = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_op: got busy=%b done=%b, required 0 0", busy, done);
         end
      end
   endtask

   task automatic test_directed();
      issue(4'b0011, 4'b0101, 1'b0); wait_check("add_ovf");  check_hold("add_ovf", 2);
      issue(4'b0110, 4'b0010, 1'b1); wait_check("sub_pos");  check_hold("sub_pos", 1);
      issue(4'b0010, 4'b0110, 1'b1); wait_check("sub_neg");  check_hold("sub_neg", 1);
      issue(4'b1111, 4'b0001, 1'b0); wait_check("add_wrap"); check_hold("add_wrap", 1);
      issue(4'b0111, 4'b1000, 1'b1); wait_check("sub_min");  check_hold("sub_min", 1);
      issue(4'b1000, 4'b1000, 1'b0); wait_check("add_negovf");
   endtask

   task automatic test_random();
      int gap;
      for (int i = 0; i < 30; i++) begin
         issue(W'($urandom), W'($urandom), 1'($urandom));
         wait_check("random");
         gap = $urandom_range(0, 2);
         if (gap > 0) check_hold("random", gap);
      end
   endtask

   task automatic test_back_to_back();
      issue(4'b0100, 4'b0011, 1'b0);
      tick();
      a     = 4'b1111;
      b     = 4'b1111;
      sub   = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_check("b2b_ignored");
      issue(4'b0101, 4'b0110, 1'b1);
      wait_check("b2b_second");
      check_hold("b2b_second", 1);
   endtask

   task automatic test_reset_mid_op();
      issue(4'b0101, 4'b0001, 1'b0);
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      void'(exp_q.pop_back());
      checks++;
      if ({busy, done, overflow, carry_out, result} !== '0) begin
         failures++;
         $display("FAIL midreset_outputs: got busy=%b done=%b ovf=%b cout=%b result=%b, required all 0",
                  busy, done, overflow, carry_out, result);
      end
      for (int i = 0; i < 2 * W + 2; i++) begin
         tick();
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || result !== '0) begin
            failures++;
            $display("FAIL midreset_no_done: got done=%b busy=%b result=%b, required 0 0 0000", done, busy, result);
         end
      end
      issue(4'b0001, 4'b0001, 1'b0);
      wait_check("after_midreset");
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      sub   = 1'b0;
      a     = '0;
      b     = '0;
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_mid_op();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
